// File: rtl/bcd_to_bin_seq_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM encodings,
// default sizing and the nibble correction constants.
package bcd_to_bin_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N_DIGITS = 4;
  localparam int DEF_W        = 14;

  // Reverse double-dabble corrects nibbles at 8 by 3; bin_to_bcd uses 5/3.
  localparam int BCD_ADJ_THRESH = 8;
  localparam int BCD_ADJ_VAL    = 3;

endpackage

// File: rtl/bcd_to_bin_seq_nibble_adj.sv
// Single BCD digit correction for the shift-right conversion step.
module bcd_nibble_adj
  import bcd_to_bin_seq_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  // A digit that reached 8 or more after a right shift borrowed 8 from the
  // digit above, which is worth 5 here, so take 3 back off.
  always_comb begin
    q = d;
    if (d >= 4'(BCD_ADJ_THRESH)) q = d - 4'(BCD_ADJ_VAL);
  end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter with a start/ready/done_tick handshake.
// The BCD part of the shift register drains into the binary part one bit per
// cycle, with per-digit correction after every shift.
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int N_DIGITS = DEF_N_DIGITS,
  parameter int W        = DEF_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] bcd,
  output logic                  ready,
  output logic                  done_tick,
  output logic                  err,
  output logic [W-1:0]          bin
);

  localparam int BW = 4 * N_DIGITS;
  localparam int SW = BW + W;
  localparam int NW = $clog2(W + 1);

  state_t          state;
  state_t          state_next;
  logic [SW-1:0]   sr;
  logic [SW-1:0]   sr_shift;
  logic [SW-1:0]   sr_adj;
  logic [NW-1:0]   n;
  logic            err_r;
  logic            illegal;

  // Flag a request that contains any digit above 9.
  always_comb begin
    illegal = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) illegal = 1'b1;
    end
  end

  assign sr_shift = sr >> 1;
  assign sr_adj[W-1:0] = sr_shift[W-1:0];

  genvar g;
  generate
    for (g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_nibble_adj u_adj (
        .d (sr_shift[W + 4*g +: 4]),
        .q (sr_adj[W + 4*g +: 4])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; an illegal request skips OP and reports straight away.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = illegal ? DONE : OP;
      OP:      if (n == NW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    ready = (state == IDLE);
  end

  // Datapath: load, shift/correct, and publish results on the DONE edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      n         <= '0;
      err_r     <= 1'b0;
      bin       <= '0;
      err       <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (illegal) begin
              err_r <= 1'b1;
              sr    <= '0;
            end else begin
              err_r <= 1'b0;
              sr    <= {bcd, {W{1'b0}}};
              n     <= NW'(W);
            end
          end
        end
        OP: begin
          sr <= sr_adj;
          n  <= n - NW'(1);
        end
        DONE: begin
          bin       <= sr[W-1:0];
          err       <= err_r;
          done_tick <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq using a result scoreboard.
module tb_bcd_to_bin_seq;

  localparam int N_DIGITS = 4;
  localparam int W        = 14;
  localparam int BW       = 4 * N_DIGITS;
  localparam int SW       = BW + W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [BW-1:0] bcd = '0;
  logic          ready;
  logic          done_tick;
  logic          err;
  logic [W-1:0]  bin;

  typedef struct {
    logic [W-1:0] bin;
    logic         err;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_count = 0;
  int   run = 0;
  int   last_run = 0;

  bcd_to_bin_seq #(.N_DIGITS(N_DIGITS), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bcd       (bcd),
    .ready     (ready),
    .done_tick (done_tick),
    .err       (err),
    .bin       (bin)
  );

  // Free-running clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point for the whole bench.
  task automatic check_output(input string tag, input int unsigned actual, input int unsigned expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  // Independent reference: plain decimal accumulation of the digits.
  function automatic void ref_model(input logic [BW-1:0] b, output logic [W-1:0] v, output logic e);
    int acc = 0;
    logic [3:0] d;
    e = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      d = b[4*i +: 4];
      if (d > 4'd9) e = 1'b1;
      acc = acc * 10 + int'(d);
    end
    v = e ? '0 : W'(acc);
  endfunction

  function automatic logic [BW-1:0] to_bcd(input int x);
    logic [BW-1:0] r = '0;
    int t = x;
    for (int i = 0; i < N_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Scoreboard consumer: compares every done_tick against the oldest request.
  always @(posedge clk) begin
    #1;
    if (!ready) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
    if (done_tick) begin
      done_count++;
      if (sb.size() == 0) check_output("unexpected_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check_output("bin", bin, mon_e.bin);
        check_output("err", err, mon_e.err);
        check_output("latency", cyc, mon_e.done_cyc);
        check_output("bcd_part_zero", int'(dut.sr[SW-1:W]), 0);
      end
    end
  end

  // Waits for IDLE, presents a request and queues the expected result.
  task automatic apply_stimulus(input logic [BW-1:0] b, input bit drop_start);
    int guard = 0;
    logic [W-1:0] v;
    logic e;
    exp_t x;
    @(negedge clk);
    while (!ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) check_output("ready_timeout", 0, 1);
    ref_model(b, v, e);
    bcd = b;
    start = 1'b1;
    x.bin = v;
    x.err = e;
    x.done_cyc = cyc + 1 + (e ? 1 : W + 1);
    sb.push_back(x);
    if (drop_start) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      check_output("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Hard stop in case something wedges beyond the per-wait bounds.
  initial begin
    #500us;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int prev_acc;
    logic [BW-1:0] rb;

    // Reset wins over a simultaneous start.
    start = 1'b1;
    bcd = 16'h1234;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check_output("rst_ready", ready, 1);
    check_output("rst_done", done_tick, 0);
    check_output("rst_err", err, 0);
    check_output("rst_bin", bin, 0);
    repeat (3) @(negedge clk);
    check_output("rst_no_done", done_count, 0);

    // Largest legal value, full latency and ready-low length.
    apply_stimulus(16'h9999, 1'b1);
    wait_idle();
    check_output("busy_len_9999", last_run, W + 1);

    apply_stimulus(16'h0000, 1'b1);
    wait_idle();
    apply_stimulus(16'h1234, 1'b1);
    wait_idle();

    // Illegal digit reports after one cycle, then a legal request clears err.
    apply_stimulus(16'h12A4, 1'b1);
    wait_idle();
    check_output("busy_len_err", last_run, 1);
    apply_stimulus(16'h0007, 1'b1);
    wait_idle();

    // Starts in OP cycle 5 and in DONE are ignored; bcd change mid-OP is harmless.
    d0 = done_count;
    apply_stimulus(16'h4321, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    bcd = 16'h9999;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_output("in_done_ready", ready, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 6) @(negedge clk);
    check_output("single_done", done_count - d0, 1);
    check_output("sb_empty_t4", sb.size(), 0);

    // Reset during OP cycle 7 aborts the conversion.
    d0 = done_count;
    apply_stimulus(16'h0555, 1'b1);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    check_output("abort_ready", ready, 1);
    check_output("abort_bin", bin, 0);
    check_output("abort_err", err, 0);
    repeat (W + 4) @(negedge clk);
    check_output("abort_no_done", done_count - d0, 0);
    apply_stimulus(16'h0042, 1'b1);
    wait_idle();

    // Start held high: back-to-back conversions one every W+2 cycles.
    prev_acc = 0;
    for (int i = 1; i <= 10; i++) begin
      apply_stimulus(to_bcd(i), 1'b0);
      if (i > 1) check_output("b2b_interval", sb[sb.size()-1].done_cyc - prev_acc, W + 2);
      prev_acc = sb[sb.size()-1].done_cyc;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Randomized legal sweep plus a few illegal patterns.
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(to_bcd($urandom_range(0, 9999)), 1'b1);
      wait_idle();
    end
    for (int i = 0; i < 4; i++) begin
      rb = to_bcd($urandom_range(0, 9999));
      rb[4*i +: 4] = 4'($urandom_range(10, 15));
      apply_stimulus(rb, 1'b1);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check_output("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
